// File: rtl/ata_pio_dev.sv
// ata_pio_dev
// Device-side ATA PIO register responder. Host strobes, selects, address and
// data are brought into the clk domain through two-flop synchronisers. A
// falling strobe edge on a valid task-file address starts an access. IORDY is
// held low for wait_cyc+1 cycles. The access then either drives a 16 x 16-bit
// register file onto the data bus (read) or commits bus data into it (write).
// The backend can also update registers through a local port and is notified
// of every committed host write.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cs0_n, cs1_n, da    ATA chip selects and device address (asynchronous)
//   dior_n, diow_n      ATA read / write strobes (asynchronous)
//   dd_i                ATA data bus input (asynchronous)
//   dd_o, dd_oe         ATA data bus output and its enable (registered)
//   iordy               ATA IORDY, low inserts wait states (registered)
//   wait_cyc            wait length, quasi-static
//   lc_we/lc_addr/lc_d  local register write port
//   wr_stb/wr_addr/wr_data  one-cycle notification of a committed host write
module ata_pio_dev #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs0_n,
  input  logic          cs1_n,
  input  logic [2:0]    da,
  input  logic          dior_n,
  input  logic          diow_n,
  input  logic [15:0]   dd_i,
  output logic [15:0]   dd_o,
  output logic          dd_oe,
  output logic          iordy,
  input  logic [TW-1:0] wait_cyc,
  input  logic          lc_we,
  input  logic [3:0]    lc_addr,
  input  logic [15:0]   lc_d,
  output logic          wr_stb,
  output logic [3:0]    wr_addr,
  output logic [15:0]   wr_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_R_WAIT = 3'd1,
    ST_R_DATA = 3'd2,
    ST_W_WAIT = 3'd3,
    ST_W_DATA = 3'd4
  } state_t;

  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

  // Synchroniser stages: *_meta_r is the first flop, *_s the usable copy.
  logic        cs0_meta_r, cs1_meta_r, dior_meta_r, diow_meta_r;
  logic [2:0]  da_meta_r;
  logic [15:0] dd_meta_r;
  logic        cs0_s, cs1_s, dior_s, diow_s;
  logic [2:0]  da_s;
  logic [15:0] dd_s;
  logic        dior_q, diow_q;

  // Access state.
  state_t        state_r, state_nxt;
  logic [TW-1:0] cnt_r, cnt_nxt;
  logic [3:0]    addr_r, addr_nxt;

  // Registered outputs.
  logic        iordy_r, iordy_nxt;
  logic        dd_oe_r, dd_oe_nxt;
  logic [15:0] dd_o_r, dd_o_nxt;
  logic        wr_stb_r;
  logic [3:0]  wr_addr_r;
  logic [15:0] wr_data_r;

  // Register file.
  logic [15:0] regs_r [16];

  // Decode helpers.
  logic       addr_valid_s;
  logic [3:0] host_addr_s;
  logic       rd_fall_s;
  logic       wr_fall_s;
  logic       commit_s;

  // Two-flop synchronisers plus the third strobe flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs0_meta_r  <= 1'b1;
      cs1_meta_r  <= 1'b1;
      dior_meta_r <= 1'b1;
      diow_meta_r <= 1'b1;
      da_meta_r   <= 3'd0;
      dd_meta_r   <= 16'h0000;
      cs0_s       <= 1'b1;
      cs1_s       <= 1'b1;
      dior_s      <= 1'b1;
      diow_s      <= 1'b1;
      da_s        <= 3'd0;
      dd_s        <= 16'h0000;
      dior_q      <= 1'b1;
      diow_q      <= 1'b1;
    end else begin
      cs0_meta_r  <= cs0_n;
      cs1_meta_r  <= cs1_n;
      dior_meta_r <= dior_n;
      diow_meta_r <= diow_n;
      da_meta_r   <= da;
      dd_meta_r   <= dd_i;
      cs0_s       <= cs0_meta_r;
      cs1_s       <= cs1_meta_r;
      dior_s      <= dior_meta_r;
      diow_s      <= diow_meta_r;
      da_s        <= da_meta_r;
      dd_s        <= dd_meta_r;
      dior_q      <= dior_s;
      diow_q      <= diow_s;
    end
  end

  // Address decode and strobe falling-edge detection.
  always_comb begin
    // Exactly one select low; cs0_s low maps to regs 0-7, cs1_s low to 8-15.
    addr_valid_s = cs0_s ^ cs1_s;
    host_addr_s  = {cs0_s, da_s};
    rd_fall_s    = ~dior_s & dior_q;
    wr_fall_s    = ~diow_s & diow_q;
  end

  // Next-state, counter and output decisions for the access FSM.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    addr_nxt  = addr_r;
    iordy_nxt = 1'b1;
    dd_oe_nxt = 1'b0;
    dd_o_nxt  = dd_o_r;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Simultaneous read and write edges are a protocol violation: ignored.
        if (addr_valid_s && rd_fall_s && !wr_fall_s) begin
          state_nxt = ST_R_WAIT;
          addr_nxt  = host_addr_s;
          cnt_nxt   = wait_cyc;
          iordy_nxt = 1'b0;
        end else if (addr_valid_s && wr_fall_s && !rd_fall_s) begin
          state_nxt = ST_W_WAIT;
          addr_nxt  = host_addr_s;
          cnt_nxt   = wait_cyc;
          iordy_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_R_WAIT: begin
        if (dior_s) begin
          // Host gave up early: release IORDY, never drive the bus.
          state_nxt = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt = ST_R_DATA;
          dd_oe_nxt = 1'b1;
          // Data is captured once here so later local writes cannot disturb it.
          dd_o_nxt  = regs_r[addr_r];
        end else begin
          cnt_nxt   = cnt_r - CNT_ONE;
          iordy_nxt = 1'b0;
        end
      end
      ST_R_DATA: begin
        if (dior_s) begin
          state_nxt = ST_IDLE;
        end else begin
          dd_oe_nxt = 1'b1;
        end
      end
      ST_W_WAIT: begin
        if (diow_s) begin
          // Early strobe release still commits whatever is on the bus.
          commit_s  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt = ST_W_DATA;
        end else begin
          cnt_nxt   = cnt_r - CNT_ONE;
          iordy_nxt = 1'b0;
        end
      end
      ST_W_DATA: begin
        if (diow_s) begin
          commit_s  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_W_DATA;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter, latched address and bus-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      addr_r  <= 4'd0;
      iordy_r <= 1'b1;
      dd_oe_r <= 1'b0;
      dd_o_r  <= 16'h0000;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      addr_r  <= addr_nxt;
      iordy_r <= iordy_nxt;
      dd_oe_r <= dd_oe_nxt;
      dd_o_r  <= dd_o_nxt;
    end
  end

  // Host-write notification registers; address/data hold between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb_r  <= 1'b0;
      wr_addr_r <= 4'd0;
      wr_data_r <= 16'h0000;
    end else if (commit_s) begin
      wr_stb_r  <= 1'b1;
      wr_addr_r <= addr_r;
      wr_data_r <= dd_s;
    end else begin
      wr_stb_r  <= 1'b0;
    end
  end

  // Register file: local port writes any time; a host commit to the same
  // address in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else begin
      if (lc_we && !(commit_s && (lc_addr == addr_r))) begin
        regs_r[lc_addr] <= lc_d;
      end
      if (commit_s) begin
        regs_r[addr_r] <= dd_s;
      end
    end
  end

  assign iordy   = iordy_r;
  assign dd_oe   = dd_oe_r;
  assign dd_o    = dd_o_r;
  assign wr_stb  = wr_stb_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

endmodule

// File: tb/tb_ata_pio_dev.sv
module tb_ata_pio_dev;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs0_n, cs1_n, dior_n, diow_n;
  logic [2:0]    da;
  logic [15:0]   dd_i;
  logic [15:0]   dd_o;
  logic          dd_oe, iordy;
  logic [TW-1:0] wait_cyc;
  logic          lc_we;
  logic [3:0]    lc_addr;
  logic [15:0]   lc_d;
  logic          wr_stb;
  logic [3:0]    wr_addr;
  logic [15:0]   wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register contents, updated from the behavioural rules only.
  logic [15:0] model [16];

  always #5 clk = ~clk;

  ata_pio_dev #(.TW(TW)) dut (
    .clk(clk), .rst(rst), .cs0_n(cs0_n), .cs1_n(cs1_n), .da(da),
    .dior_n(dior_n), .diow_n(diow_n), .dd_i(dd_i), .dd_o(dd_o),
    .dd_oe(dd_oe), .iordy(iordy), .wait_cyc(wait_cyc), .lc_we(lc_we),
    .lc_addr(lc_addr), .lc_d(lc_d), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  task automatic lc_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); lc_we = 1'b1; lc_addr = a; lc_d = d;
    @(negedge clk); lc_we = 1'b0;
    model[a] = d;
  endtask

  // Full host read cycle; returns what was observed on the bus.
  task automatic host_read(input logic c0, input logic c1, input logic [2:0] a,
                           input bit mid_lc, input logic [15:0] mid_d,
                           output logic [15:0] data, output logic [15:0] data_after,
                           output int low_cyc, output bit got_oe, output int rel_cyc);
    got_oe = 1'b0; low_cyc = 0; rel_cyc = 0; data = 16'h0000;
    @(negedge clk); cs0_n = c0; cs1_n = c1; da = a;
    @(negedge clk); dior_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dd_oe) begin got_oe = 1'b1; data = dd_o; break; end
      if (!iordy) low_cyc++;
    end
    data_after = data;
    if (mid_lc) begin
      lc_we = 1'b1; lc_addr = {c0, a}; lc_d = mid_d;
      @(posedge clk); #1; lc_we = 1'b0;
      @(posedge clk); #1; data_after = dd_o;
      model[{c0, a}] = mid_d;
    end
    @(negedge clk); dior_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (!dd_oe) begin rel_cyc = i; break; end
    end
    @(negedge clk); cs0_n = 1'b1; cs1_n = 1'b1;
    @(negedge clk);
  endtask

  // Full host write cycle; hold<0 waits for IORDY to return, else releases
  // the strobe after 'hold' cycles. Optional local write lands on the commit edge.
  task automatic host_write(input logic c0, input logic c1, input logic [2:0] a,
                            input logic [15:0] d, input int hold,
                            input bit collide, input logic [3:0] c_addr, input logic [15:0] c_d,
                            output int low_cyc, output int stb_cyc, output int stb_cnt,
                            output logic [3:0] s_addr, output logic [15:0] s_data);
    low_cyc = 0; stb_cyc = 0; stb_cnt = 0; s_addr = 4'd0; s_data = 16'h0000;
    @(negedge clk); cs0_n = c0; cs1_n = c1; da = a; dd_i = d;
    @(negedge clk); diow_n = 1'b0;
    if (hold < 0) begin
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (!iordy) low_cyc++;
        else if (low_cyc > 0) break;
      end
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!iordy) low_cyc++;
      end
    end
    @(negedge clk); diow_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (collide && i == 2) begin lc_we = 1'b1; lc_addr = c_addr; lc_d = c_d; end
      if (collide && i == 3) lc_we = 1'b0;
      if (wr_stb) begin
        stb_cnt++;
        if (stb_cyc == 0) begin stb_cyc = i; s_addr = wr_addr; s_data = wr_data; end
      end
    end
    if (collide) model[c_addr] = c_d;
    model[{c0, a}] = d;  // host write wins any collision
    @(negedge clk); cs0_n = 1'b1; cs1_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d, da2; int lo, rc; bit g;
    if (iordy !== 1'b1 || dd_oe !== 1'b0 || dd_o !== 16'h0000) begin
      $display("FAIL por_bus: iordy=%b dd_oe=%b dd_o=%h expected 1 0 0000", iordy, dd_oe, dd_o); n_fail++;
    end
    n_checks++;
    if (wr_stb !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 16'h0000) begin
      $display("FAIL por_wr: wr_stb=%b wr_addr=%h wr_data=%h expected 0 0 0000", wr_stb, wr_addr, wr_data); n_fail++;
    end
    n_checks++;
    lc_write(4'd3, 16'h7E7E);
    @(negedge clk); wait_cyc = 8'd2; cs0_n = 1'b0; cs1_n = 1'b1; da = 3'd3;
    @(negedge clk); dior_n = 1'b0;
    g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dd_oe) begin g = 1'b1; break; end
    end
    if (!g || dd_o !== 16'h7E7E) begin
      $display("FAIL rst_pre_read: oe=%b dd_o=%h expected 1 7e7e", g, dd_o); n_fail++;
    end
    n_checks++;
    @(negedge clk); rst = 1'b1; dior_n = 1'b1; cs0_n = 1'b1;
    @(posedge clk); #1;
    if (iordy !== 1'b1 || dd_oe !== 1'b0 || dd_o !== 16'h0000 || wr_stb !== 1'b0) begin
      $display("FAIL rst_mid_read: iordy=%b dd_oe=%b dd_o=%h expected 1 0 0000", iordy, dd_oe, dd_o); n_fail++;
    end
    n_checks++;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    for (int r = 0; r < 16; r++) begin
      logic [3:0] ra;
      ra = 4'(r);
      host_read(ra[3], ~ra[3], ra[2:0], 1'b0, 16'h0000, d, da2, lo, g, rc);
      if (!g || d !== model[r]) begin
        $display("FAIL rst_reg%0d: oe=%b data=%h expected 1 %h", r, g, d, model[r]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_write_read();
    int lo, sc, sn, rc; logic [3:0] sa; logic [15:0] sd, d, d2; bit g;
    @(negedge clk); wait_cyc = 8'd3;
    host_write(1'b0, 1'b1, 3'd2, 16'hA5C3, -1, 1'b0, 4'd0, 16'h0000, lo, sc, sn, sa, sd);
    if (lo != 4) begin $display("FAIL wr_iordy_low: got %0d expected 4", lo); n_fail++; end
    n_checks++;
    if (sc != 3 || sn != 1) begin
      $display("FAIL wr_stb_timing: edge=%0d width=%0d expected 3 1", sc, sn); n_fail++;
    end
    n_checks++;
    if (sa !== 4'd2 || sd !== 16'hA5C3) begin
      $display("FAIL wr_stb_payload: addr=%h data=%h expected 2 a5c3", sa, sd); n_fail++;
    end
    n_checks++;
    host_read(1'b0, 1'b1, 3'd2, 1'b0, 16'h0000, d, d2, lo, g, rc);
    if (!g || d !== model[2]) begin
      $display("FAIL wr_readback: oe=%b data=%h expected 1 %h", g, d, model[2]); n_fail++;
    end
    n_checks++;
    if (lo != 4 || rc != 3) begin
      $display("FAIL rd_timing: low=%0d release=%0d expected 4 3", lo, rc); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_zero_wait_cs1();
    int lo, rc; logic [15:0] d, d2; bit g;
    @(negedge clk); wait_cyc = 8'd0;
    lc_write(4'd15, 16'h1234);
    host_read(1'b1, 1'b0, 3'd7, 1'b1, 16'hBEEF, d, d2, lo, g, rc);
    if (!g || d !== 16'h1234 || lo != 1) begin
      $display("FAIL cs1_zero_wait: oe=%b data=%h low=%0d expected 1 1234 1", g, d, lo); n_fail++;
    end
    n_checks++;
    if (d2 !== 16'h1234) begin
      $display("FAIL rd_hold_vs_local: dd_o=%h expected 1234", d2); n_fail++;
    end
    n_checks++;
    host_read(1'b1, 1'b0, 3'd7, 1'b0, 16'h0000, d, d2, lo, g, rc);
    if (!g || d !== model[15]) begin
      $display("FAIL local_write_landed: data=%h expected %h", d, model[15]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_invalid_sel();
    int bad, lo, rc; logic [15:0] d, d2; bit g;
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      @(negedge clk); cs0_n = (k == 1); cs1_n = (k == 1); da = 3'd4;
      @(negedge clk); dior_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (i == 4) dior_n = 1'b1;
        if (iordy !== 1'b1 || dd_oe !== 1'b0) bad++;
      end
      if (bad != 0) begin
        $display("FAIL invalid_sel%0d: %0d bad samples expected 0", k, bad); n_fail++;
      end
      n_checks++;
    end
    @(negedge clk); cs0_n = 1'b1; cs1_n = 1'b1;
    host_read(1'b0, 1'b1, 3'd2, 1'b0, 16'h0000, d, d2, lo, g, rc);
    if (!g || d !== model[2]) begin
      $display("FAIL after_invalid: oe=%b data=%h expected 1 %h", g, d, model[2]); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_read_abort();
    int low_seen, oe_seen, hi_at;
    @(negedge clk); wait_cyc = 8'd10; cs0_n = 1'b0; cs1_n = 1'b1; da = 3'd1;
    @(negedge clk); dior_n = 1'b0;
    low_seen = 0; oe_seen = 0; hi_at = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (!iordy) low_seen++;
    end
    @(negedge clk); dior_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (dd_oe) oe_seen++;
      if (iordy && hi_at == 0) hi_at = i;
    end
    if (low_seen == 0 || oe_seen != 0) begin
      $display("FAIL rd_abort_bus: low=%0d oe_samples=%0d expected >0 0", low_seen, oe_seen); n_fail++;
    end
    n_checks++;
    if (hi_at < 1 || hi_at > 3) begin
      $display("FAIL rd_abort_iordy: high after %0d edges expected 1..3", hi_at); n_fail++;
    end
    n_checks++;
    @(negedge clk); cs0_n = 1'b1; cs1_n = 1'b1;
  endtask

  task automatic test_write_abort();
    int lo, sc, sn, rc; logic [3:0] sa; logic [15:0] sd, d, d2; bit g;
    @(negedge clk); wait_cyc = 8'd10;
    host_write(1'b0, 1'b1, 3'd5, 16'h00FF, 4, 1'b1, 4'd5, 16'hFFFF, lo, sc, sn, sa, sd);
    if (sc != 3 || sn != 1 || sa !== 4'd5 || sd !== 16'h00FF) begin
      $display("FAIL wr_abort_stb: edge=%0d width=%0d addr=%h data=%h expected 3 1 5 00ff", sc, sn, sa, sd); n_fail++;
    end
    n_checks++;
    host_write(1'b0, 1'b1, 3'd6, 16'h1111, 4, 1'b1, 4'd7, 16'h2222, lo, sc, sn, sa, sd);
    @(negedge clk); wait_cyc = 8'd2;
    for (int r = 5; r <= 7; r++) begin
      logic [3:0] ra;
      ra = 4'(r);
      host_read(1'b0, 1'b1, ra[2:0], 1'b0, 16'h0000, d, d2, lo, g, rc);
      if (!g || d !== model[r]) begin
        $display("FAIL collide_reg%0d: data=%h expected %h", r, d, model[r]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    int lo, sc, sn, rc, w, op; logic [3:0] a, sa; logic [15:0] v, sd, d, d2; bit g;
    for (int it = 0; it < 40; it++) begin
      w  = $urandom_range(0, 5);
      op = $urandom_range(0, 2);
      a  = 4'($urandom_range(0, 15));
      v  = 16'($urandom);
      @(negedge clk); wait_cyc = 8'(w);
      if (op == 0) begin
        lc_write(a, v);
      end else if (op == 1) begin
        host_write(a[3], ~a[3], a[2:0], v, -1, 1'b0, 4'd0, 16'h0000, lo, sc, sn, sa, sd);
        if (lo != w + 1 || sc != 3 || sa !== a || sd !== v) begin
          $display("FAIL rand_wr%0d: low=%0d edge=%0d addr=%h data=%h expected %0d 3 %h %h",
                   it, lo, sc, sa, sd, w + 1, a, v); n_fail++;
        end
        n_checks++;
      end else begin
        host_read(a[3], ~a[3], a[2:0], 1'b0, 16'h0000, d, d2, lo, g, rc);
        if (!g || d !== model[a] || lo != w + 1) begin
          $display("FAIL rand_rd%0d: oe=%b data=%h low=%0d expected 1 %h %0d",
                   it, g, d, lo, model[a], w + 1); n_fail++;
        end
        n_checks++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs0_n = 1'b1; cs1_n = 1'b1; da = 3'd0; dior_n = 1'b1; diow_n = 1'b1;
    dd_i = 16'h0000; wait_cyc = 8'd0; lc_we = 1'b0; lc_addr = 4'd0; lc_d = 16'h0000;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_zero_wait_cs1();
    test_invalid_sel();
    test_read_abort();
    test_write_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
